// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the programmable-flag FIFO.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Register-array storage: sync write port, registered sync read port.
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Array is deliberately not reset; only the output register is.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_prog_flag.sv
// Parametrised sync FIFO with programmable almost flags,
// occupancy count, sticky error flags and synchronous flush.
module fifo_prog_flag
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           d_in,
  input  logic                       rd,
  output logic [WIDTH-1:0]           d_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [cnt_w(DEPTH)-1:0]    count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
  localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);

  if ((1 << AW) != DEPTH || DEPTH < 2) begin : g_bad_depth
    $error("fifo_prog_flag: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_prog_flag: AF_THRESH out of range");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_prog_flag: AE_THRESH out of range");
  end

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_af;
  logic          r_ae;
  logic          r_ovf;
  logic          r_udf;

  logic          w_wr_ok;
  logic          w_rd_ok;
  logic          w_we;
  logic          w_re;
  logic [CW-1:0] w_count_nxt;

  // A read on a full FIFO frees the slot the write needs.
  assign w_wr_ok = wr && (!r_full || rd);
  assign w_rd_ok = rd && !r_empty;
  assign w_we    = w_wr_ok && !clr && !rst;
  assign w_re    = w_rd_ok && !clr && !rst;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_ok) w_count_nxt = w_count_nxt + 1'b1;
    if (w_rd_ok) w_count_nxt = w_count_nxt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == C_DEPTH);
      r_empty <= (w_count_nxt == '0);
      r_af    <= (w_count_nxt >= C_AF);
      r_ae    <= (w_count_nxt <= C_AE);
      if (wr && !w_wr_ok) r_ovf <= 1'b1;
      if (rd && !w_rd_ok) r_udf <= 1'b1;
    end
  end

  fifo_mem_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_rst   (rst),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (d_in),
    .i_re    (w_re),
    .i_raddr (r_rd_ptr),
    .o_rdata (d_out)
  );

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_prog_flag.sv
// Directed self-checking bench for fifo_prog_flag (8x16, AF=14, AE=2).
module tb_fifo_prog_flag;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst, clr, wr, rd;
  logic [W-1:0]  d_in;
  logic [W-1:0]  d_out;
  logic          full, empty, almost_full, almost_empty;
  logic [CW-1:0] count;
  logic          overflow, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_prog_flag #(
    .WIDTH(W), .DEPTH(D), .AF_THRESH(14), .AE_THRESH(2)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr(wr), .d_in(d_in), .rd(rd),
    .d_out(d_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr = 1'b0; rd = 1'b0; clr = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic fill16();
    for (int i = 1; i <= 16; i++) begin
      wr = 1'b1; d_in = 8'(i); tick();
    end
    idle();
  endtask

  task automatic test_reset();
    clr = 1'b1; wr = 1'b1; rd = 1'b1; d_in = 8'hEE;
    rst = 1'b1; tick(); tick(); idle();
    n_checks++;
    if ({d_out, count, empty, full, almost_empty, almost_full,
         overflow, underflow} !== {8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0,
         1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: d_out=%h cnt=%0d e=%b f=%b ae=%b af=%b o=%b u=%b",
               d_out, count, empty, full, almost_empty, almost_full,
               overflow, underflow);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      wr = 1'b1; d_in = 8'(i); tick();
      n_checks++;
      if (count !== CW'(i) || almost_empty !== (i <= 2) ||
          almost_full !== (i >= 14) || full !== (i == 16) ||
          empty !== 1'b0) begin
        n_fail++;
        $display("FAIL fill[%0d]: cnt=%0d ae=%b af=%b f=%b e=%b", i,
                 count, almost_empty, almost_full, full, empty);
      end
    end
    d_in = 8'hAA; tick(); idle();
    n_checks++;
    if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: ovf=%b cnt=%0d f=%b want 1 16 1",
               overflow, count, full);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      rd = 1'b1; tick();
      n_checks++;
      if (d_out !== 8'(i) || count !== CW'(16 - i) ||
          empty !== (i == 16) || underflow !== 1'b0) begin
        n_fail++;
        $display("FAIL drain[%0d]: d_out=%h cnt=%0d e=%b u=%b want %h",
                 i, d_out, count, empty, underflow, 8'(i));
      end
    end
    tick(); idle();
    n_checks++;
    if (underflow !== 1'b1 || d_out !== 8'h10 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL underflow: u=%b d_out=%h cnt=%0d want 1 10 0",
               underflow, d_out, count);
    end
  endtask

  task automatic test_full_simul();
    do_reset();
    fill16();
    wr = 1'b1; rd = 1'b1; d_in = 8'h55; tick(); idle();
    n_checks++;
    if (d_out !== 8'h01 || count !== 5'd16 || full !== 1'b1 ||
        overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_wr_rd: d_out=%h cnt=%0d f=%b o=%b want 01 16 1 0",
               d_out, count, full, overflow);
    end
    for (int i = 2; i <= 17; i++) begin
      logic [7:0] exp;
      exp = (i == 17) ? 8'h55 : 8'(i);
      rd = 1'b1; tick();
      n_checks++;
      if (d_out !== exp) begin
        n_fail++;
        $display("FAIL full_drain[%0d]: d_out=%h want %h", i, d_out, exp);
      end
    end
    idle();
  endtask

  task automatic test_empty_simul();
    wr = 1'b1; rd = 1'b1; d_in = 8'h33; tick(); idle();
    n_checks++;
    if (count !== 5'd1 || underflow !== 1'b1 || d_out !== 8'h55 ||
        empty !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_wr_rd: cnt=%0d u=%b d_out=%h e=%b want 1 1 55 0",
               count, underflow, d_out, empty);
    end
    rd = 1'b1; tick(); idle();
    n_checks++;
    if (d_out !== 8'h33 || count !== 5'd0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_follow: d_out=%h cnt=%0d e=%b want 33 0 1",
               d_out, count, empty);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] exp;
    logic [7:0] seed;
    bit up;
    do_reset();
    seed = 8'h10;
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; d_in = seed; q.push_back(seed); seed = seed + 8'd7; tick();
    end
    idle();
    up = 1'b1;
    for (int it = 0; it < 40; it++) begin
      for (int ph = 0; ph < 2; ph++) begin
        wr = up || ph == 1;
        rd = !up || ph == 1;
        d_in = seed;
        exp = 8'h00;
        if (rd) exp = q.pop_front();
        if (wr) begin q.push_back(seed); seed = seed + 8'd7; end
        tick();
        n_checks++;
        if (count !== CW'(q.size()) || (rd && d_out !== exp)) begin
          n_fail++;
          $display("FAIL wrap[%0d.%0d]: cnt=%0d want %0d d_out=%h want %h",
                   it, ph, count, q.size(), d_out, exp);
        end
      end
      if (q.size() >= 12) up = 1'b0;
      if (q.size() <= 5)  up = 1'b1;
    end
    idle();
  endtask

  task automatic test_clr_rst();
    do_reset();
    rd = 1'b1; tick(); idle();
    for (int i = 0; i < 9; i++) begin
      wr = 1'b1; d_in = 8'(8'hC0 + i); tick();
    end
    clr = 1'b1; wr = 1'b1; d_in = 8'h99; tick(); idle();
    n_checks++;
    if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1 ||
        almost_full !== 1'b0 || full !== 1'b0 || underflow !== 1'b1 ||
        overflow !== 1'b0 || d_out !== 8'h00) begin
      n_fail++;
      $display("FAIL clr: cnt=%0d e=%b ae=%b af=%b f=%b u=%b o=%b d=%h",
               count, empty, almost_empty, almost_full, full,
               underflow, overflow, d_out);
    end
    wr = 1'b1; d_in = 8'h77; tick(); idle();
    rd = 1'b1; tick(); idle();
    n_checks++;
    if (d_out !== 8'h77 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL clr_reuse: d_out=%h cnt=%0d want 77 0", d_out, count);
    end
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; d_in = 8'(8'hA0 + i); tick();
    end
    rst = 1'b1; wr = 1'b1; rd = 1'b1; tick(); idle();
    n_checks++;
    if ({d_out, count, empty, full, almost_empty, almost_full,
         overflow, underflow} !== {8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0,
         1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_rst: d_out=%h cnt=%0d e=%b f=%b ae=%b af=%b o=%b u=%b",
               d_out, count, empty, full, almost_empty, almost_full,
               overflow, underflow);
    end
  endtask

  initial begin
    idle(); d_in = '0;
    test_reset();
    test_fill();
    test_drain();
    test_full_simul();
    test_empty_simul();
    test_wrap();
    test_clr_rst();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_prog_flag.md
# fifo_prog_flag

Parametrised synchronous FIFO, successor to the fixed 8-bit/16-deep flagged FIFO. Adds configurable width and depth, programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a synchronous flush. Sits between a producer and a consumer in the same clock domain as the general-purpose buffering primitive.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous flush of pointers/count; ignored while rst=1
- wr  in  1  write request
- d_in  in  WIDTH  write data
- rd  in  1  read request
- d_out  out  WIDTH  read data, registered
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  $clog2(DEPTH+1)  current occupancy
- overflow  out  1  sticky: write rejected
- underflow  out  1  sticky: read rejected

## Operation
- Pointers wr_ptr, rd_ptr are $clog2(DEPTH) bits, wrap naturally at DEPTH; count tracks occupancy separately.
- Write accepted (wr_ok) when wr && (!full || rd). Stores d_in at mem[wr_ptr], wr_ptr+1.
- Read accepted (rd_ok) when rd && !empty. d_out <= mem[rd_ptr], rd_ptr+1.
- count_next = count + wr_ok − rd_ok; all flags derived from count_next and registered.
- Full + wr + rd: both accepted, count unchanged, no overflow.
- Empty + wr + rd: write accepted, read rejected, underflow set, d_out holds.
- wr while full without rd: data dropped, pointers unchanged, overflow set.
- rd while empty: underflow set, d_out holds.
- overflow/underflow clear only on rst.
- clr: wr_ptr, rd_ptr, count → 0; empty=1, full=0, almost_empty=1, almost_full=0; d_out and sticky flags hold; any wr/rd in the same cycle ignored.
- Memory contents are not reset.

## Timing
- Reset (rst=1 at edge): d_out=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, pointers 0. rst overrides clr, wr and rd; reset mid-stream discards all data.
- Write-to-flag latency 1 cycle: count/flags reflect a write on the edge that accepts it.
- Read latency 1 cycle: d_out valid after the accepting edge, holds until the next accepted read.
- Written word readable on the cycle after the write edge (no fall-through when empty).
- Error flags set on the edge of the rejected request.

## Structure
- Shared package fifo_pkg: clog2 helper function, default WIDTH/DEPTH constants, count-width calculation.
- One sub-module: fifo_mem_dp — WIDTH×DEPTH register array, one synchronous write port, one synchronous registered read port with read enable; no reset on array.
- Top holds pointers, count, flag registers and accept logic.
- Elaboration check: DEPTH power of two, thresholds in range.

## Test plan
(WIDTH=8, DEPTH=16, AF_THRESH=14, AE_THRESH=2)
- Reset then write 0x01..0x10 (16 writes) -> almost_empty drops after 3rd write, almost_full rises after 14th, full after 16th, count=16; 17th write 0xAA -> dropped, overflow=1, count=16.
- Read 16 from full -> d_out 0x01..0x10 in order, each 1 cycle after rd edge; empty=1 after 16th; extra rd -> underflow=1, d_out stays 0x10.
- Full, simultaneous wr(0x55)+rd -> d_out=oldest word, count=16, full stays 1, overflow unchanged; 0x55 read out last after draining.
- Empty, simultaneous wr(0x33)+rd -> count=1, underflow=1, next cycle rd -> d_out=0x33.
- Wrap: 40 interleaved write/read pairs with occupancy 5–12 -> data order preserved across pointer wrap, count matches model every cycle.
- clr with count=9 and wr asserted -> count=0, empty=1, overflow/underflow unchanged; rst mid-stream -> all outputs at reset values next cycle, sticky flags cleared.
